// File: rtl/pwm_pkg.sv
// Shared constants and FSM state type for the PWM period/high-time calculator.
package pwm_pkg;

    localparam int unsigned CLK_HZ_DEF = 50_000_000;
    localparam int unsigned PCT_DIV    = 100;
    localparam int unsigned CNT_W_DEF  = 24;
    localparam int unsigned CNT_MAX    = (1 << CNT_W_DEF) - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIV_P,
        ST_MUL,
        ST_DIV_H,
        ST_COMMIT
    } pwm_state_e;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, the first bit resolved on the start edge.
module seq_divider #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         busy,
    output logic         done
);

    localparam int unsigned CW = $clog2(W);

    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  dvd_q, dvd_d;
    logic [W-1:0]  dsr_q, dsr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [W-1:0]  rem_in, dvd_in, dsr_in, rem_next, dvd_next;
    logic [W:0]    shifted, diff;
    logic          ge;

    always_comb begin
        rem_in   = start ? '0 : rem_q;
        dvd_in   = start ? dividend : dvd_q;
        dsr_in   = start ? divisor : dsr_q;
        shifted  = {rem_in, dvd_in[W-1]};
        diff     = shifted - {1'b0, dsr_in};
        ge       = (shifted >= {1'b0, dsr_in});
        rem_next = ge ? diff[W-1:0] : shifted[W-1:0];
        dvd_next = {dvd_in[W-2:0], ge};
    end

    always_comb begin
        rem_d  = rem_q;
        dvd_d  = dvd_q;
        dsr_d  = dsr_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start) begin
            rem_d  = rem_next;
            dvd_d  = dvd_next;
            dsr_d  = divisor;
            cnt_d  = CW'(W - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d = rem_next;
            dvd_d = dvd_next;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            dvd_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            dvd_q  <= dvd_d;
            dsr_q  <= dsr_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign quotient = dvd_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: rtl/pwm_param_calc.sv
// Converts freq_hz/duty_pct into PWM period/high-time cycle counts with one shared sequential divider.
module pwm_param_calc
    import pwm_pkg::*;
#(
    parameter int unsigned CLK_HZ = CLK_HZ_DEF,
    parameter int unsigned FREQ_W = 9,
    parameter int unsigned DUTY_W = 8,
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned DIV_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FREQ_W-1:0] freq_hz,
    input  logic [DUTY_W-1:0] duty_pct,
    input  logic              start,
    output logic [CNT_W-1:0]  period_cyc,
    output logic [CNT_W-1:0]  htime_cyc,
    output logic              valid,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] CNT_ONES = '1;

    pwm_state_e        state_q, state_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0]  pcalc_q, pcalc_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  htime_q, htime_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pending_q, pending_d;

    logic              go;
    logic              div_start, div_busy, div_done;
    logic [DIV_W-1:0]  div_dividend, div_divisor, div_quo;

    seq_divider #(.W(DIV_W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .quotient (div_quo),
        .busy     (div_busy),
        .done     (div_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            freq_q    <= '0;
            duty_q    <= '0;
            pcalc_q   <= '0;
            period_q  <= '0;
            htime_q   <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            freq_q    <= freq_d;
            duty_q    <= duty_d;
            pcalc_q   <= pcalc_d;
            period_q  <= period_d;
            htime_q   <= htime_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pending_q <= pending_d;
        end
    end

    assign go = (state_q == ST_IDLE) && (start || pending_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (go) state_d = (freq_hz == '0) ? ST_COMMIT : ST_DIV_P;
            ST_DIV_P:  if (div_done) state_d = ST_MUL;
            ST_MUL:    state_d = ST_DIV_H;
            ST_DIV_H:  if (div_done) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        freq_d    = freq_q;
        duty_d    = duty_q;
        pcalc_d   = pcalc_q;
        period_d  = period_q;
        htime_d   = htime_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pending_d = pending_q;
        if (state_q != ST_IDLE && start) pending_d = 1'b1;
        if (go) begin
            pending_d = 1'b0;
            busy_d    = 1'b1;
            freq_d    = freq_hz;
            duty_d    = (duty_pct > DUTY_W'(PCT_DIV)) ? DUTY_W'(PCT_DIV) : duty_pct;
            pcalc_d   = '0;
        end
        if (state_q == ST_DIV_P && div_done)
            pcalc_d = (div_quo > DIV_W'(CNT_ONES)) ? CNT_ONES : div_quo[CNT_W-1:0];
        // A zero period can only come from the freq_hz=0 shortcut, which never ran a divide.
        if (state_q == ST_COMMIT) begin
            period_d = pcalc_q;
            htime_d  = (pcalc_q == '0) ? '0 : div_quo[CNT_W-1:0];
            valid_d  = 1'b1;
            done_d   = 1'b1;
            busy_d   = 1'b0;
        end
    end

    always_comb begin
        div_start    = 1'b0;
        div_dividend = DIV_W'(CLK_HZ);
        div_divisor  = DIV_W'(freq_q);
        if (state_q == ST_DIV_P) begin
            div_start = !div_busy && !div_done;
        end else if (state_q == ST_MUL) begin
            div_start    = 1'b1;
            div_dividend = DIV_W'(pcalc_q) * DIV_W'(duty_q);
            div_divisor  = DIV_W'(PCT_DIV);
        end
    end

    assign period_cyc = period_q;
    assign htime_cyc  = htime_q;
    assign valid      = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_pwm_param_calc.sv
// Directed bench for pwm_param_calc: transaction-level reference model plus literal spot checks.
module tb_pwm_param_calc;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [8:0]  freq_hz = '0;
    logic [7:0]  duty_pct = '0;
    logic        start = 1'b0;
    logic [23:0] period_cyc, htime_cyc;
    logic        valid, busy, done;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;
    int done_cnt = 0;

    pwm_param_calc #(
        .CLK_HZ (50_000_000),
        .FREQ_W (9),
        .DUTY_W (8),
        .CNT_W  (24),
        .DIV_W  (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .freq_hz    (freq_hz),
        .duty_pct   (duty_pct),
        .start      (start),
        .period_cyc (period_cyc),
        .htime_cyc  (htime_cyc),
        .valid      (valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Reference model: a request accepted at edge k publishes its result at edge k+67 (k+1 for 0 Hz).
    longint exp_period = 0, exp_htime = 0;
    bit     exp_valid = 0, exp_busy = 0, exp_done = 0;
    bit     m_busy = 0, m_pending = 0;
    int     m_left = 0;
    longint m_p = 0, m_h = 0;

    function automatic void model_calc(input longint f, input longint d, output longint p, output longint h);
        longint dc;
        dc = (d > 100) ? 100 : d;
        if (f == 0) begin
            p = 0;
            h = 0;
        end else begin
            p = 50_000_000 / f;
            if (p > 16_777_215) p = 16_777_215;
            h = (p * dc) / 100;
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_period = 0; exp_htime = 0;
            exp_valid = 0; exp_busy = 0; exp_done = 0;
            m_busy = 0; m_pending = 0; m_left = 0;
        end else begin
            exp_done = 0;
            if (m_busy) begin
                if (start) m_pending = 1;
                m_left = m_left - 1;
                if (m_left == 0) begin
                    exp_period = m_p;
                    exp_htime  = m_h;
                    exp_valid  = 1;
                    exp_done   = 1;
                    m_busy     = 0;
                end
            end else if (start || m_pending) begin
                m_pending = 0;
                model_calc(freq_hz, duty_pct, m_p, m_h);
                m_left = (freq_hz == 0) ? 1 : 67;
                m_busy = 1;
            end
            exp_busy = m_busy;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("cmp_period", period_cyc, exp_period);
            chk("cmp_htime", htime_cyc, exp_htime);
            chk("cmp_valid", valid, exp_valid);
            chk("cmp_busy", busy, exp_busy);
            chk("cmp_done", done, exp_done);
            if (done) done_cnt++;
        end
    end

    task automatic do_start(input int f, input int d);
        @(negedge clk);
        freq_hz  = 9'(f);
        duty_pct = 8'(d);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 200) chk("done_timeout", cyc, -1);
    endtask

    int lat;

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("rst_period", period_cyc, 0);
        chk("rst_htime", htime_cyc, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        check_en = 1'b1;

        // 1: nominal request and latency
        do_start(200, 99);
        chk("t1_busy", busy, 1);
        wait_done(lat);
        chk("t1_latency", lat, 67);
        chk("t1_period", period_cyc, 250000);
        chk("t1_htime", htime_cyc, 247500);
        @(negedge clk);
        chk("t1_done_one_cycle", done, 0);

        // 2: outputs hold their previous result while computing
        do_start(196, 97);
        repeat (30) @(negedge clk);
        chk("t2_hold_period", period_cyc, 250000);
        chk("t2_hold_htime", htime_cyc, 247500);
        wait_done(lat);
        chk("t2_latency", lat + 30, 67);
        chk("t2_period", period_cyc, 255102);
        chk("t2_htime", htime_cyc, 247448);

        // 3: zero frequency shortcut
        do_start(0, 50);
        wait_done(lat);
        chk("t3_latency", lat, 1);
        chk("t3_period", period_cyc, 0);
        chk("t3_htime", htime_cyc, 0);
        chk("t3_valid", valid, 1);

        // 4: saturation and duty clamp
        do_start(1, 50);
        wait_done(lat);
        chk("t4_sat_period", period_cyc, 16777215);
        chk("t4_sat_htime", htime_cyc, 8388607);
        do_start(100, 150);
        wait_done(lat);
        chk("t4_clamp_period", period_cyc, 500000);
        chk("t4_clamp_htime", htime_cyc, 500000);

        // 5: starts while busy collapse into a single follow-up run
        @(negedge clk);
        done_cnt = 0;
        do_start(10, 40);
        repeat (10) @(negedge clk);
        do_start(50, 60);
        repeat (10) @(negedge clk);
        do_start(80, 60);
        repeat (10) @(negedge clk);
        do_start(100, 60);
        wait_done(lat);
        chk("t5_first_period", period_cyc, 5000000);
        chk("t5_first_htime", htime_cyc, 2000000);
        @(negedge clk);
        wait_done(lat);
        chk("t5_final_period", period_cyc, 500000);
        chk("t5_final_htime", htime_cyc, 300000);
        repeat (80) @(negedge clk);
        chk("t5_done_pulses", done_cnt, 2);

        // 6: asynchronous reset during the second divide
        do_start(200, 50);
        repeat (50) @(negedge clk);
        chk("t6_busy_before_rst", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_period", period_cyc, 0);
        chk("t6_rst_htime", htime_cyc, 0);
        chk("t6_rst_valid", valid, 0);
        chk("t6_rst_busy", busy, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        do_start(250, 20);
        wait_done(lat);
        chk("t6_latency", lat, 67);
        chk("t6_period", period_cyc, 200000);
        chk("t6_htime", htime_cyc, 40000);
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
